ahb_ram_slave: RTL
==================

Name: ahb_ram_slave

Overview:
- AHB-Lite single-port SRAM slave that sits directly downstream of the AHB arbiter's device-1 port (RAM window 0xF000_0000–0xF000_03FF).
- Serves code fetches and data loads/stores with byte, halfword and word writes, and a configurable number of wait states.
- Returns a two-cycle ERROR response for misaligned, oversize or out-of-window transfers.
- Includes write-to-read forwarding, so back-to-back store→load to the same word returns the new data.

Parameters:
- BASE_ADDR, 32'hF000_0000, byte address of the first RAM location.
- SIZE_BYTES, 1024, RAM size in bytes; power of two, ≥8.
- WAIT_STATES, 0, extra HREADY-low cycles inserted into every OKAY data phase (0–15).

Ports:
- HCLK  in  1  clock; all state changes on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- HSEL  in  1  slave select, from the arbiter.
- HADDR  in  32  byte address.
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
- HWRITE  in  1  1 = write, 0 = read.
- HSIZE  in  3  000 byte, 001 halfword, 010 word.
- HBUST  in  3  burst type; ignored, every beat is treated independently.
- HWDATA  in  32  write data, valid in the data phase.
- HRDATA  out  32  read data, valid when HREADY=1 in a read data phase.
- HREADY  out  1  data phase complete.
- HRESP  out  2  00 OKAY, 01 ERROR.

Behaviour:
- Reset (HRESETn low, asynchronous): HREADY=1, HRESP=00, HRDATA=0, state IDLE, no pending write, wait counter 0. RAM contents are not reset. Reset asserted mid-transfer abandons it; a pending write is discarded.
- Address phase is accepted on a rising edge when HSEL=1, HTRANS[1]=1 and HREADY=1. IDLE/BUSY or HSEL=0 → zero-wait OKAY, no access.
- Error check at acceptance; any one of these is an error:
  - HSIZE>010.
  - HSIZE=001 with HADDR[0]=1.
  - HSIZE=010 with HADDR[1:0]≠0.
  - Offset (HADDR−BASE_ADDR) ≥ SIZE_BYTES, computed unsigned 32-bit so wrap below BASE is also out of range.
- Word index = offset[log2(SIZE_BYTES)-1:2]. Byte lanes are little-endian: byte lane = offset[1:0]; halfword uses lanes {offset[1],0} and {offset[1],1}.
- States and transitions:
  - IDLE: no data phase outstanding.
    - Valid accept with WAIT_STATES=0 → DATA.
    - Valid accept with WAIT_STATES>0 → WAIT, counter loaded with WAIT_STATES.
    - Error accept → ERR1.
  - WAIT: HREADY=0, HRESP=00. Counter decrements each cycle; when it reaches 0 → DATA.
  - DATA: HREADY=1, HRESP=00; the transfer completes this cycle. A new accept in the same cycle follows the IDLE rules, giving pipelined back-to-back beats; otherwise → IDLE.
  - ERR1: HREADY=0, HRESP=01; → ERR2.
  - ERR2: HREADY=1, HRESP=01. A new address phase presented in this cycle is accepted per the IDLE rules.
- Writes:
  - Lanes and index are registered at the address phase.
  - HWDATA is sampled on the edge ending the DATA cycle (HREADY=1) and committed to RAM on that edge, updating only the selected lanes.
  - An errored write never modifies RAM.
- Reads:
  - HRDATA is the full 32-bit word, registered so it is valid throughout the DATA cycle. The master extracts lanes.
  - Read with WAIT_STATES=0: the word is read at the address-phase edge.
  - Read with WAIT_STATES>0: the word is read on the edge entering DATA.
  - Forwarding: if a write to the same word commits on the same edge the read word is sampled, HRDATA = written lanes merged over the old word.
- HRDATA holds its last value outside read DATA cycles. After an error or a write it is not required to change.
- HBUST and HTRANS SEQ vs NONSEQ are treated identically.

Test Plan:
- Reset → HREADY=1, HRESP=00, HRDATA=0. Release reset, then idle 3 cycles with HSEL=0 → outputs unchanged.
- WAIT_STATES=0: word write 0xDEADBEEF to 0xF000_0010, immediately followed by a word read of 0xF000_0010 → read DATA cycle HRDATA=0xDEADBEEF, HREADY=1 on both beats (forwarding path).
- Byte write 0x55 to 0xF000_0013 over word 0x11223344, then word read → HRDATA=0x55223344. Halfword write 0xAAAA to 0xF000_0010, then read → 0x5522AAAA.
- Misaligned word read at 0xF000_0002 → one cycle HREADY=0/HRESP=01, next cycle HREADY=1/HRESP=01. Write of 0xFFFFFFFF at 0xF000_0400 (out of range) → same ERROR pair, and RAM word 0 and word 255 unchanged.
- WAIT_STATES=2: read at 0xF000_0010 → HREADY low for exactly 2 cycles, then HREADY=1 with correct data. BUSY/IDLE transfers → HREADY stays 1.
- Assert HRESETn low during the WAIT state of a write → HREADY=1, HRESP=00 immediately (asynchronously). The written word keeps its old value on a subsequent read.

Source files
------------

// File: rtl/ahb_ram_slave.sv
// AHB-Lite single-port SRAM slave with byte/halfword/word writes,
// programmable wait states, two-cycle ERROR responses and
// write-to-read forwarding for back-to-back store/load to one word.
module ahb_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hF000_0000,
  parameter int unsigned SIZE_BYTES  = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBUST,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam int unsigned AW    = $clog2(SIZE_BYTES);
  localparam int unsigned IW    = AW - 2;
  localparam int unsigned WORDS = SIZE_BYTES / 4;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic            wr_q, wr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            hready_q, hready_d;
  logic [1:0]      hresp_q, hresp_d;
  logic [31:0]     rdata_q, rdata_d;
  logic [31:0]     mem_q [WORDS];

  logic [31:0]     off_s;
  logic            accept_s;
  logic            size_err_s;
  logic            oor_s;
  logic            err_s;
  logic [3:0]      be_s;
  logic            commit_s;
  logic            rd_fire_s;
  logic [IW-1:0]   rd_idx_s;
  logic [31:0]     rd_word_s;
  logic            unused_s;

  // Replace the enabled byte lanes of old_w with the matching lanes of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[i*8 +: 8] = new_w[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = old_w[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Burst type and SEQ/NONSEQ distinction carry no meaning for this slave.
  assign unused_s = ^{HBUST, HTRANS[0]};

  assign off_s    = HADDR - BASE_ADDR;
  assign accept_s = HSEL & HTRANS[1] & hready_q;
  assign oor_s    = (off_s >= 32'(SIZE_BYTES));
  assign err_s    = size_err_s | oor_s;
  assign commit_s = (state_q == ST_DATA) & wr_q;

  // Decode transfer size into byte-lane enables and alignment errors.
  always_comb begin
    size_err_s = 1'b0;
    be_s       = 4'b0000;
    case (HSIZE)
      3'b000: begin
        size_err_s = 1'b0;
        be_s       = 4'b0001 << off_s[1:0];
      end
      3'b001: begin
        size_err_s = HADDR[0];
        be_s       = off_s[1] ? 4'b1100 : 4'b0011;
      end
      3'b010: begin
        size_err_s = (HADDR[1:0] != 2'b00);
        be_s       = 4'b1111;
      end
      default: begin
        size_err_s = 1'b1;
        be_s       = 4'b0000;
      end
    endcase
  end

  // Select when and where the read word is sampled, merging a same-edge write.
  always_comb begin
    rd_fire_s = 1'b0;
    rd_idx_s  = idx_q;
    if (WAIT_STATES == 0) begin
      rd_fire_s = accept_s & ~err_s & ~HWRITE;
      rd_idx_s  = off_s[AW-1:2];
    end else begin
      rd_fire_s = (state_q == ST_WAIT) & (cnt_q <= 4'd1) & ~wr_q;
      rd_idx_s  = idx_q;
    end
    rd_word_s = mem_q[rd_idx_s];
    if (commit_s && (idx_q == rd_idx_s)) begin
      rd_word_s = lane_merge(mem_q[rd_idx_s], HWDATA, be_q);
    end else begin
      rd_word_s = mem_q[rd_idx_s];
    end
    rdata_d = rd_fire_s ? rd_word_s : rdata_q;
  end

  // Next-state, address-phase capture and registered response outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    idx_d   = idx_q;
    be_d    = be_q;
    case (state_q)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d = off_s[AW-1:2];
          be_d  = be_s;
          if (err_s) begin
            state_d = ST_ERR1;
            wr_d    = 1'b0;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
            wr_d    = HWRITE;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = 4'(WAIT_STATES);
            wr_d    = HWRITE;
          end
        end else begin
          state_d = ST_IDLE;
          wr_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q <= 4'd1) begin
          state_d = ST_DATA;
          cnt_d   = 4'd0;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        wr_d    = 1'b0;
      end
    endcase
    hready_d = (state_d == ST_IDLE) | (state_d == ST_DATA) | (state_d == ST_ERR2);
    hresp_d  = ((state_d == ST_ERR1) | (state_d == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  // Control and output registers; a reset abandons any transfer in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      be_q     <= 4'b0000;
      hready_q <= 1'b1;
      hresp_q  <= 2'b00;
      rdata_q  <= 32'h0000_0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      idx_q    <= idx_d;
      be_q     <= be_d;
      hready_q <= hready_d;
      hresp_q  <= hresp_d;
      rdata_q  <= rdata_d;
    end
  end

  // RAM array write port; contents are deliberately not reset.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      mem_q[idx_q] <= lane_merge(mem_q[idx_q], HWDATA, be_q);
    end
  end

  assign HRDATA = rdata_q;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule
